// File: rtl/mul4_product_accumulator_if.sv
// mul4_product_accumulator_if
// Bundles the product-stream handshake and the result handshake of the
// product accumulator.
//   start/len             : run request and run length (producer -> block)
//   prod_valid/prod       : product stream in (producer -> block)
//   prod_ready            : block accepts a product this cycle
//   res_valid/res/res_ovf : accumulated result out (block -> consumer)
//   res_ready             : consumer accepts the result
//   busy                  : block is inside a run (ACC or HOLD)
// Modports: master = producer/consumer side, slave = accumulator side.
interface mul4_product_accumulator_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             prod_valid;
  logic [7:0]       prod;
  logic             prod_ready;
  logic             res_valid;
  logic [ACC_W-1:0] res;
  logic             res_ovf;
  logic             res_ready;
  logic             busy;

  modport master (
    output start, len, prod_valid, prod, res_ready,
    input  prod_ready, res_valid, res, res_ovf, busy
  );

  modport slave (
    input  start, len, prod_valid, prod, res_ready,
    output prod_ready, res_valid, res, res_ovf, busy
  );
endinterface

// File: rtl/mul4_product_accumulator.sv
// mul4_product_accumulator
// Sums a run of len 8-bit products taken over a valid/ready stream and
// presents the sum plus a sticky carry-out flag over a second valid/ready
// handshake. Sits behind the 4x4 multiplier to form a MAC datapath.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mul4_product_accumulator_if (start/len, product
//           stream, result stream, busy)
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
module mul4_product_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  mul4_product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             ovf_r;
  logic             ovf_nxt_s;
  logic [CNT_W-1:0] remaining_r;
  logic [CNT_W-1:0] remaining_nxt_s;
  logic [ACC_W:0]   sum_s;
  logic             xfer_s;
  logic             prod_ready_r;
  logic             res_valid_r;
  logic             busy_r;

  // A product is taken only while accumulating; prod_ready is high exactly then.
  assign xfer_s = (state_r == ST_ACC) && bus.prod_valid;

  // One extra bit on the adder captures the carry out of the accumulator.
  assign sum_s = {1'b0, acc_r} + {{(ACC_W-7){1'b0}}, bus.prod};

  // Next-state and datapath update for the run sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    ovf_nxt_s       = ovf_r;
    remaining_nxt_s = remaining_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          acc_nxt_s = '0;
          ovf_nxt_s = 1'b0;
          if (bus.len == CNT_W'(0)) begin
            state_nxt_s = ST_HOLD;
          end else begin
            remaining_nxt_s = bus.len;
            state_nxt_s     = ST_ACC;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (xfer_s) begin
          acc_nxt_s       = sum_s[ACC_W-1:0];
          ovf_nxt_s       = ovf_r | sum_s[ACC_W];
          remaining_nxt_s = remaining_r - CNT_W'(1);
          if (remaining_r == CNT_W'(1)) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_ACC;
          end
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_HOLD: begin
        // start is deliberately not looked at here, even alongside res_ready.
        if (bus.res_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= '0;
      ovf_r       <= 1'b0;
      remaining_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      ovf_r       <= ovf_nxt_s;
      remaining_r <= remaining_nxt_s;
    end
  end

  // Handshake outputs are registered from the next state so they line up
  // with the state register without a decode after the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_ready_r <= 1'b0;
      res_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      prod_ready_r <= (state_nxt_s == ST_ACC);
      res_valid_r  <= (state_nxt_s == ST_HOLD);
      busy_r       <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.prod_ready = prod_ready_r;
  assign bus.res_valid  = res_valid_r;
  assign bus.busy       = busy_r;
  // The result is the accumulator itself; it only changes on a transfer or
  // when a new run clears it, so it holds steady through HOLD and after.
  assign bus.res        = acc_r;
  assign bus.res_ovf    = ovf_r;

endmodule
